// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline-control types and index constants
package rv_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DEFER = 2'd2
   } pipe_state_e;

   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_EX = 2;

   localparam int HSRC_EX  = 0;
   localparam int HSRC_BUS = 1;

   localparam logic [31:0] ZERO_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - redirect/hold/flush bundle between core and pipe_ctrl
// PIPE_CTRL_PERF_EN adds the performance counter outputs.
interface pipe_ctrl_if #(
   parameter int NUM_STAGES   = 3,
   parameter int NUM_HOLD_SRC = 2
);
   logic                    jump_en_i;
   logic [31:0]             jump_addr_i;
   logic                    int_jump_en_i;
   logic [31:0]             int_jump_addr_i;
   logic [NUM_HOLD_SRC-1:0] hold_req_i;
   logic                    jump_en_o;
   logic [31:0]             jump_addr_o;
   logic [NUM_STAGES-1:0]   hold_o;
   logic [NUM_STAGES-1:0]   flush_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]             stall_cnt_o;
   logic [31:0]             flush_cnt_o;
`endif

   modport master (
      output jump_en_i, jump_addr_i, int_jump_en_i, int_jump_addr_i, hold_req_i,
`ifdef PIPE_CTRL_PERF_EN
      input  stall_cnt_o, flush_cnt_o,
`endif
      input  jump_en_o, jump_addr_o, hold_o, flush_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, int_jump_en_i, int_jump_addr_i, hold_req_i,
`ifdef PIPE_CTRL_PERF_EN
      output stall_cnt_o, flush_cnt_o,
`endif
      output jump_en_o, jump_addr_o, hold_o, flush_o
   );

endinterface

// File: rtl/pipe_hold_merge.sv
// rtl/pipe_hold_merge.sv - decodes per-source stall requests into a per-stage freeze vector
module pipe_hold_merge #(
   parameter int NUM_STAGES   = 3,
   parameter int NUM_HOLD_SRC = 2,
   parameter int LVL_W        = 2,
   parameter logic [NUM_HOLD_SRC*LVL_W-1:0] HOLD_LVL = {2'd1, 2'd2}
) (
   input  logic [NUM_HOLD_SRC-1:0] hold_req,
   output logic [NUM_STAGES-1:0]   hold
);

   // HOLD_LVL lists sources left to right: the most significant field is source 0.
   always_comb begin
      hold = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         for (int i = 0; i < NUM_HOLD_SRC; i++) begin
            if (hold_req[i] && (int'(HOLD_LVL[(NUM_HOLD_SRC-1-i)*LVL_W +: LVL_W]) >= s))
               hold[s] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - redirect arbitration, hold/flush generation and bus-stall redirect deferral
// PIPE_CTRL_PERF_EN adds stall and redirect counters.
module pipe_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int NUM_HOLD_SRC = 2,
   parameter logic [NUM_HOLD_SRC*$clog2(NUM_STAGES)-1:0] HOLD_LVL = {2'd1, 2'd2},
   parameter int FLUSH_CYCLES = 1,
   parameter int BUS_SRC      = HSRC_BUS
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave ctl
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_FLUSH = FLUSH;
   localparam logic [1:0] S_DEFER = DEFER;

   localparam logic [NUM_STAGES-1:0] FLUSH_MASK = {1'b0, {(NUM_STAGES-1){1'b1}}};
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   logic [1:0]            state, state_nx;
   logic [2:0]            flush_cnt, flush_cnt_nx;
   logic                  pend_valid, pend_valid_nx;
   logic [31:0]           pend_addr, pend_addr_nx;
   logic                  issue, flush_act;
   logic [31:0]           issue_addr;
   logic [NUM_STAGES-1:0] hold_merge;
   logic                  bus_hold;
   logic [31:0]           win_addr;

   pipe_hold_merge #(
      .NUM_STAGES  (NUM_STAGES),
      .NUM_HOLD_SRC(NUM_HOLD_SRC),
      .LVL_W       ($clog2(NUM_STAGES)),
      .HOLD_LVL    (HOLD_LVL)
   ) u_hold_merge (
      .hold_req(ctl.hold_req_i),
      .hold    (hold_merge)
   );

   assign bus_hold = ctl.hold_req_i[BUS_SRC];
   // The trap unit owns epc, so a simultaneous EX redirect is simply dropped.
   assign win_addr = ctl.int_jump_en_i ? ctl.int_jump_addr_i : ctl.jump_addr_i;

   always_comb begin
      state_nx      = state;
      flush_cnt_nx  = flush_cnt;
      pend_valid_nx = pend_valid;
      pend_addr_nx  = pend_addr;
      issue         = 1'b0;
      issue_addr    = ZERO_ADDR;
      flush_act     = 1'b0;
      case (state)
         S_FLUSH: begin
            flush_act = 1'b1;
            if (ctl.int_jump_en_i) begin
               issue      = 1'b1;
               issue_addr = ctl.int_jump_addr_i;
            end else if (flush_cnt <= 3'd1) begin
               state_nx     = S_IDLE;
               flush_cnt_nx = 3'd0;
            end else begin
               flush_cnt_nx = flush_cnt - 3'd1;
            end
         end
         S_DEFER: begin
            if (bus_hold) begin
               if (ctl.int_jump_en_i)
                  pend_addr_nx = ctl.int_jump_addr_i;
            end else if (pend_valid) begin
               issue         = 1'b1;
               issue_addr    = ctl.int_jump_en_i ? ctl.int_jump_addr_i : pend_addr;
               pend_valid_nx = 1'b0;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            if (ctl.jump_en_i || ctl.int_jump_en_i) begin
               if (bus_hold) begin
                  pend_addr_nx  = win_addr;
                  pend_valid_nx = 1'b1;
                  state_nx      = S_DEFER;
               end else begin
                  issue      = 1'b1;
                  issue_addr = win_addr;
               end
            end
         end
      endcase
      if (issue) begin
         flush_act = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_nx     = S_FLUSH;
            flush_cnt_nx = FLUSH_RELOAD;
         end else begin
            state_nx = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         flush_cnt  <= 3'd0;
         pend_valid <= 1'b0;
         pend_addr  <= ZERO_ADDR;
      end else begin
         state      <= state_nx;
         flush_cnt  <= flush_cnt_nx;
         pend_valid <= pend_valid_nx;
         pend_addr  <= pend_addr_nx;
      end
   end

   // Flush overrides any stall on the flushed stages so the bubble actually lands.
   assign ctl.jump_en_o   = issue;
   assign ctl.jump_addr_o = issue_addr;
   assign ctl.flush_o     = flush_act ? FLUSH_MASK : '0;
   assign ctl.hold_o      = hold_merge | (flush_act ? FLUSH_MASK : '0);

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, redir_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         redir_cnt <= 32'd0;
      end else begin
         if (|ctl.hold_o)
            stall_cnt <= stall_cnt + 32'd1;
         if (issue)
            redir_cnt <= redir_cnt + 32'd1;
      end
   end

   assign ctl.stall_cnt_o = stall_cnt;
   assign ctl.flush_cnt_o = redir_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.NUM_STAGES(3), .NUM_HOLD_SRC(2)) pif ();

   pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk(clk),
      .rst(rst),
      .ctl(pif.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic je, input logic [31:0] ja, input logic ie,
                        input logic [31:0] ia, input logic [1:0] hr);
      @(posedge clk);
      #1;
      pif.jump_en_i       = je;
      pif.jump_addr_i     = ja;
      pif.int_jump_en_i   = ie;
      pif.int_jump_addr_i = ia;
      pif.hold_req_i      = hr;
      #1;
   endtask

   // Packed as {jump_en, jump_addr, hold, flush}.
   task automatic expect_out(input string tag, input logic je, input logic [31:0] ja,
                             input logic [2:0] h, input logic [2:0] f);
      chk(tag, 64'({pif.jump_en_o, pif.jump_addr_o, pif.hold_o, pif.flush_o}),
          64'({je, ja, h, f}));
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out(tag, 1'b0, 32'h0, 3'b000, 3'b000);
   endtask

   initial begin
      pif.jump_en_i       = 1'b0;
      pif.jump_addr_i     = 32'h0;
      pif.int_jump_en_i   = 1'b0;
      pif.int_jump_addr_i = 32'h0;
      pif.hold_req_i      = 2'b00;
      #12;
      expect_out("reset", 1'b0, 32'h0, 3'b000, 3'b000);
`ifdef PIPE_CTRL_PERF_EN
      chk("reset_stall_cnt", 64'(pif.stall_cnt_o), 64'd0);
      chk("reset_flush_cnt", 64'(pif.flush_cnt_o), 64'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++) idle("idle");

      drive(1'b1, 32'h100, 1'b0, 32'h0, 2'b00);
      expect_out("ex_jump", 1'b1, 32'h100, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("ex_flush2", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("ex_done");
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_flush_cnt", 64'(pif.flush_cnt_o), 64'd1);
      chk("perf_stall_cnt", 64'(pif.stall_cnt_o), 64'd2);
`endif

      drive(1'b1, 32'h100, 1'b1, 32'h8000_0004, 2'b00);
      expect_out("arb_int_wins", 1'b1, 32'h8000_0004, 3'b011, 3'b011);
      drive(1'b1, 32'h500, 1'b0, 32'h0, 2'b00);
      expect_out("ex_in_flush_ignored", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("arb_done");

      drive(1'b1, 32'h100, 1'b0, 32'h0, 2'b00);
      expect_out("pre_int_flush", 1'b1, 32'h100, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b1, 32'h700, 2'b00);
      expect_out("int_in_flush", 1'b1, 32'h700, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("int_flush_reload", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("int_flush_done");

      drive(1'b1, 32'h200, 1'b0, 32'h0, 2'b10);
      expect_out("defer_c1", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b1, 32'h999, 1'b0, 32'h0, 2'b10);
      expect_out("defer_c2_ex_ignored", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b10);
      expect_out("defer_c3", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b10);
      expect_out("defer_c4", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("defer_replay", 1'b1, 32'h200, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("defer_flush2", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("defer_done");

      drive(1'b0, 32'h0, 1'b1, 32'h1000, 2'b10);
      expect_out("defer_int1", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b1, 32'h2000, 2'b10);
      expect_out("defer_int2", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("defer_int_overwrite", 1'b1, 32'h2000, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("defer_int_flush2", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("defer_int_done");

      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b01);
      expect_out("ex_hold_only", 1'b0, 32'h0, 3'b011, 3'b000);
      drive(1'b1, 32'h300, 1'b0, 32'h0, 2'b01);
      expect_out("ex_hold_jump", 1'b1, 32'h300, 3'b011, 3'b011);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      expect_out("ex_hold_flush2", 1'b0, 32'h0, 3'b011, 3'b011);
      idle("ex_hold_done");

      drive(1'b1, 32'h400, 1'b0, 32'h0, 2'b10);
      expect_out("rst_defer_enter", 1'b0, 32'h0, 3'b111, 3'b000);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b10);
      expect_out("rst_defer_hold", 1'b0, 32'h0, 3'b111, 3'b000);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b10);
      expect_out("rst_after_hold", 1'b0, 32'h0, 3'b111, 3'b000);
      idle("rst_release_no_jump");
      idle("rst_release_quiet");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the RV32 core, succeeding the single-hold, zero-state jump/hold block.
- Arbitrates two jump sources: EX branch/jump and interrupt/trap redirect.
- Merges N parametrised hold requesters into per-stage hold and flush vectors.
- Holds flush for a programmable number of cycles after a redirect.
- Buffers a redirect that arrives while a bus stall is active and replays it when the stall releases.

Parameters:
- NUM_STAGES, 3, number of pipeline stages (0 = IF, ascending toward EX).
- NUM_HOLD_SRC, 2, number of hold requesters (src 0 = EX multi-cycle op, src 1 = bus wait).
- HOLD_LVL, {2'd1,2'd2}, packed NUM_HOLD_SRC x clog2(NUM_STAGES) field; src i freezes stages 0..HOLD_LVL[i].
- FLUSH_CYCLES, 1, number of cycles flush_o stays asserted after a redirect (1..7).
- BUS_SRC, 1, index of the hold source whose stall defers a redirect.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- jump_en_i  in  1  EX redirect request
- jump_addr_i  in  32  EX redirect target
- int_jump_en_i  in  1  interrupt/trap redirect request
- int_jump_addr_i  in  32  interrupt/trap target
- hold_req_i  in  NUM_HOLD_SRC  per-source stall requests
- jump_en_o  out  1  redirect pulse to PC
- jump_addr_o  out  32  redirect target
- hold_o  out  NUM_STAGES  per-stage freeze
- flush_o  out  NUM_STAGES  per-stage bubble insert (stages 0..NUM_STAGES-2)

Behaviour:
- Reset: async on rst high. jump_en_o=0, jump_addr_o=0, hold_o=0, flush_o=0, state=IDLE, pend_valid=0, flush_cnt=0.
- Arbitration: int_jump_en_i beats jump_en_i. When both are asserted in the same cycle, the EX request is dropped; the trap unit owns epc.
- Hold merge (combinational): hold_o[s]=1 if any active source i has HOLD_LVL[i] >= s.
- FSM states: IDLE, FLUSH, DEFER.
- IDLE, no request: all outputs 0 except hold_o, which follows the merge.
- IDLE, request and hold_req_i[BUS_SRC]=0:
  - Same cycle: jump_en_o=1 and jump_addr_o=winner's target (zero latency, as the current pipeline requires).
  - Same cycle: flush_o[0..NUM_STAGES-2]=1 and hold_o[0..NUM_STAGES-2] is forced high.
  - If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in IDLE.
- IDLE, request while bus hold is high: latch the winner into pend_addr, set pend_valid, go to DEFER. jump_en_o stays 0 in that cycle.
- FLUSH: flush_o stays asserted and flush_cnt decrements each cycle; return to IDLE when flush_cnt reaches 1. A new interrupt redirect in FLUSH is honoured immediately: pulse jump_en_o and reload flush_cnt. A new EX redirect in FLUSH is ignored, since EX holds a flushed bubble.
- DEFER:
  - While the bus hold is high: hold_o follows the merge and there is no flush.
  - An interrupt arriving in DEFER overwrites pend_addr. An EX redirect arriving in DEFER is ignored.
  - First cycle with the bus hold low: jump_en_o=1, jump_addr_o=pend_addr, flush asserted, pend_valid cleared, then go to FLUSH or IDLE exactly as from IDLE.
- jump_addr_o is 0 whenever jump_en_o=0.
- An EX-source hold with no bus hold does not defer a jump; the redirect wins and flush overrides the stall.
- flush_o[NUM_STAGES-1] is always 0.
- rst asserted mid-FLUSH or mid-DEFER discards the pending target and the counter.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o counts cycles with any hold_o bit set.
  - flush_cnt_o counts redirects issued.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - state enum (IDLE=2'd0, FLUSH=2'd1, DEFER=2'd2)
  - stage index constants (STG_IF=0, STG_ID=1, STG_EX=2)
  - hold-source index constants (HSRC_EX=0, HSRC_BUS=1)
  - 32-bit ZERO_ADDR
- One sub-module, pipe_hold_merge: purely combinational HOLD_LVL decoding of hold_req_i into the per-stage hold vector. It is reusable by the future dual-issue core.

Test Plan:
- Reset release, idle, no requests -> all outputs 0 for 10 cycles.
- jump_en_i=1, addr 0x0000_0100, FLUSH_CYCLES=2 -> same cycle: jump_en_o=1, addr 0x100, flush_o=3'b011. Next cycle: flush_o=3'b011, jump_en_o=0. Third cycle: flush_o=0.
- jump_en_i and int_jump_en_i together (0x100 / 0x8000_0004) -> jump_addr_o=0x8000_0004; the EX target never appears.
- hold_req_i=2'b10 for 4 cycles, jump to 0x200 in cycle 1 -> jump_en_o=0 in cycles 1-4 and hold_o=3'b111 (default HOLD_LVL). Cycle 5: jump_en_o=1, addr 0x200, flush asserted.
- hold_req_i=2'b01 alone -> hold_o=3'b011. A jump to 0x300 in the same cycle -> immediate pulse, flush_o=3'b011.
- rst pulsed in DEFER with pend 0x400 -> after reset, hold release produces no jump_en_o.
- With PIPE_CTRL_PERF_EN -> after the 2-cycle-flush test: flush_cnt_o=1 and stall_cnt_o=2.
